// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB plus an iterative shift-add MUL,
// with valid/ready handshakes on both the operation and the result side.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             IllegalOp,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // the sender holds valid and its payload until then, and payload is sampled only there.

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_result;
    logic             alu_illegal;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;

    assign dbg_state = state;

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (ALUOperation)
            OP_AND:  alu_result = SrcA & SrcB;
            OP_OR:   alu_result = SrcA | SrcB;
            OP_ADD:  alu_result = SrcA + SrcB;
            OP_SUB:  alu_result = SrcA - SrcB;
            OP_MUL:  alu_result = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // One shift-add step; the last of the WIDTH steps writes the result directly,
    // which keeps MUL latency at exactly WIDTH+1 cycles from the accept cycle.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign cnt_next = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            IllegalOp <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (ALUOperation == OP_MUL) begin
                            mcand  <= SrcA;
                            mplier <= SrcB;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= ST_MUL;
                        end else begin
                            ALUResult <= alu_result;
                            Zero      <= (alu_result == '0);
                            IllegalOp <= alu_illegal;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt_next;
                    if (cnt_next == CNT_W'(WIDTH)) begin
                        ALUResult <= acc_next;
                        Zero      <= (acc_next == '0);
                        IllegalOp <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
